// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two requesters.
// One op in flight: accept -> ISSUE (ALU evaluates) -> RESP (held until consumed).
module alu_share_arbiter #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic [2:0]        rsp_flags,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_ov,
  input  logic              alu_zero,
  input  logic              alu_neg
);

  typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

  state_t            state_reg, state_next;
  logic              owner_reg, owner_next;
  logic              last_served_reg, last_served_next;
  logic [OP_W-1:0]   op_reg, op_next;
  logic [DATA_W-1:0] a_reg, a_next;
  logic [DATA_W-1:0] b_reg, b_next;
  logic [DATA_W-1:0] result_reg, result_next;
  logic [2:0]        flags_reg, flags_next;

  logic [1:0] req_valid, req_ready, grant, rsp_valid, rsp_ready;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};

  // On a tie the requester that was not served last wins.
  assign grant[0] = req_valid[0] & (~req_valid[1] | last_served_reg);
  assign grant[1] = req_valid[1] & (~req_valid[0] | ~last_served_reg);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign req_ready[gi] = ~rst & (state_reg == IDLE) & grant[gi];
      assign rsp_valid[gi] = (state_reg == RESP) & (owner_reg == 1'(gi));
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign rsp_result = result_reg;
  assign rsp_flags  = flags_reg;
  assign alu_op     = op_reg;
  assign alu_a      = a_reg;
  assign alu_b      = b_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IDLE;
      owner_reg       <= 1'b0;
      last_served_reg <= 1'b1;
      op_reg          <= '0;
      a_reg           <= '0;
      b_reg           <= '0;
      result_reg      <= '0;
      flags_reg       <= '0;
    end else begin
      state_reg       <= state_next;
      owner_reg       <= owner_next;
      last_served_reg <= last_served_next;
      op_reg          <= op_next;
      a_reg           <= a_next;
      b_reg           <= b_next;
      result_reg      <= result_next;
      flags_reg       <= flags_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    owner_next       = owner_reg;
    last_served_next = last_served_reg;
    op_next          = op_reg;
    a_next           = a_reg;
    b_next           = b_reg;
    result_next      = result_reg;
    flags_next       = flags_reg;
    case (state_reg)
      IDLE: begin
        if (grant[0]) begin
          op_next    = req0_op;
          a_next     = req0_a;
          b_next     = req0_b;
          owner_next = 1'b0;
          state_next = ISSUE;
        end else if (grant[1]) begin
          op_next    = req1_op;
          a_next     = req1_a;
          b_next     = req1_b;
          owner_next = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        result_next = alu_out;
        flags_next  = {alu_ov, alu_zero, alu_neg};
        state_next  = RESP;
      end
      RESP: begin
        if (rsp_ready[owner_reg]) begin
          last_served_next = owner_reg;
          state_next       = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
